// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: shadow scoreboard of in-flight register writes beside
// the DOF stage. Forwards results onto the A/B operand buses, stalls the
// front end on a not-yet-ready operand, flushes IF/DOF on a taken branch,
// and keeps saturating stall/flush event counters.
module hazard_forward_unit #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DEPTH    = 2,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    dof_valid,
    input  logic [ADDR_W-1:0]       dof_aa,
    input  logic [ADDR_W-1:0]       dof_ba,
    input  logic                    dof_a_used,
    input  logic                    dof_b_used,
    input  logic                    dof_rw,
    input  logic [ADDR_W-1:0]       dof_da,
    input  logic [1:0]              dof_md,
    input  logic [DATA_W-1:0]       rf_a,
    input  logic [DATA_W-1:0]       rf_b,
    input  logic [DEPTH*DATA_W-1:0] stg_data,
    input  logic                    ex_branch_taken,
    output logic [DATA_W-1:0]       a_data,
    output logic [DATA_W-1:0]       b_data,
    output logic [3:0]              fwd_a_sel,
    output logic [3:0]              fwd_b_sel,
    output logic                    stall,
    output logic                    flush,
    output logic                    bubble,
    output logic [CNT_W-1:0]        stall_cnt,
    output logic [CNT_W-1:0]        flush_cnt
);

    // Scoreboard: entry 0 = EX, entry DEPTH-1 = write-back
    logic [DEPTH-1:0]  sb_v;
    logic [DEPTH-1:0]  sb_rw;
    logic [ADDR_W-1:0] sb_da [DEPTH];
    logic [1:0]        sb_md [DEPTH];

    logic a_src_ok;
    logic b_src_ok;
    logic a_found;
    logic b_found;
    logic haz_a;
    logic haz_b;

    // Register 0 is never a hazard or forward source when ZERO_REG is set
    assign a_src_ok = !((ZERO_REG != 0) && (dof_aa == '0));
    assign b_src_ok = !((ZERO_REG != 0) && (dof_ba == '0));

    // Source A: youngest matching entry wins; not-yet-ready entry raises a hazard
    always_comb begin
        fwd_a_sel = 4'd0;
        a_data    = rf_a;
        haz_a     = 1'b0;
        a_found   = 1'b0;
        if (dof_valid && dof_a_used && a_src_ok) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (!a_found && sb_v[i] && sb_rw[i] && (sb_da[i] == dof_aa)) begin
                    a_found = 1'b1;
                    if ((sb_md[i] == 2'd0) || (i >= int'(LOAD_LAT))) begin
                        fwd_a_sel = 4'(i + 1);
                        a_data    = stg_data[i*DATA_W +: DATA_W];
                    end else begin
                        haz_a = 1'b1;
                    end
                end
            end
        end
    end

    // Source B: same selection rules as source A
    always_comb begin
        fwd_b_sel = 4'd0;
        b_data    = rf_b;
        haz_b     = 1'b0;
        b_found   = 1'b0;
        if (dof_valid && dof_b_used && b_src_ok) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (!b_found && sb_v[i] && sb_rw[i] && (sb_da[i] == dof_ba)) begin
                    b_found = 1'b1;
                    if ((sb_md[i] == 2'd0) || (i >= int'(LOAD_LAT))) begin
                        fwd_b_sel = 4'(i + 1);
                        b_data    = stg_data[i*DATA_W +: DATA_W];
                    end else begin
                        haz_b = 1'b1;
                    end
                end
            end
        end
    end

    // Hazard control: a taken branch squashes the stalled instruction anyway
    always_comb begin
        stall  = (haz_a | haz_b) & ~ex_branch_taken;
        flush  = ex_branch_taken;
        bubble = stall | flush;
    end

    // Scoreboard shift; entry 0 takes the DOF instruction or a bubble
    always_ff @(posedge clock) begin
        if (reset) begin
            sb_v  <= '0;
            sb_rw <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                sb_da[i] <= '0;
                sb_md[i] <= 2'd0;
            end
        end else begin
            if (bubble) begin
                sb_v[0]  <= 1'b0;
                sb_rw[0] <= 1'b0;
                sb_da[0] <= '0;
                sb_md[0] <= 2'd0;
            end else begin
                sb_v[0]  <= dof_valid;
                sb_rw[0] <= dof_rw;
                sb_da[0] <= dof_da;
                sb_md[0] <= dof_md;
            end
            for (int i = 1; i < int'(DEPTH); i++) begin
                sb_v[i]  <= sb_v[i-1];
                sb_rw[i] <= sb_rw[i-1];
                sb_da[i] <= sb_da[i-1];
                sb_md[i] <= sb_md[i-1];
            end
        end
    end

    // Saturating event counters; reset wins over increment
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule
